multi_clock_div: RTL and testbench

MULTI_CLOCK_DIV -- requirements
Module: multi_clock_div

---
 rtl/multi_clock_div.sv | 173 +++++++++++++++++
 tb/tb_multi_clock_div.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_clock_div.sv
// multi_clock_div: NUM_CH independent integer clock dividers running from pll_clk.
// Each channel runs its own IDLE/RUN/STOPPING controller and a period counter.
// Divide ratios are double-buffered so a new ratio only applies on a period boundary.
// Each channel also has a staged, active-low reset output that releases after
// RST_STAGES completed output periods.
module multi_clock_div #(
    parameter int NUM_CH     = 2,
    parameter int DIV_W      = 3,
    parameter int DIV_RESET  = 2,
    parameter int RST_STAGES = 3
) (
    input  logic                    pll_clk,
    input  logic                    resetb,
    input  logic                    ext_reset,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*DIV_W-1:0] div_sel,
    input  logic [NUM_CH-1:0]       div_load,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       div_done,
    output logic [NUM_CH-1:0]       resetb_sync
);

    // The counter carries one extra bit so that a ratio of 0 or 1 can be
    // promoted to 2 even when DIV_W is 1.
    localparam int CW = DIV_W + 1;

    localparam logic [DIV_W-1:0] RATIO_INIT = DIV_W'(DIV_RESET);
    localparam logic [3:0]       RST_MAX    = 4'(RST_STAGES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    // Effective divisor: ratios below 2 behave as 2.
    function automatic logic [CW-1:0] eff_div(input logic [DIV_W-1:0] r);
        logic [CW-1:0] rr;
        rr = {1'b0, r};
        return (rr < CW'(2)) ? CW'(2) : rr;
    endfunction

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CW-1:0]    cnt;
        logic [CW-1:0]    cnt_nxt;
        logic [CW-1:0]    d_cur;
        logic [DIV_W-1:0] ratio;
        logic [DIV_W-1:0] ratio_nxt;
        logic [DIV_W-1:0] pend;
        logic [DIV_W-1:0] pend_nxt;
        logic [DIV_W-1:0] sel;
        logic             pend_vld;
        logic             pend_vld_nxt;
        logic             idle_ld;
        logic             idle_ld_nxt;
        logic             clk_q;
        logic             clk_nxt;
        logic             done_q;
        logic             done_nxt;
        logic [3:0]       rst_cnt;
        logic [3:0]       rst_cnt_nxt;
        logic             at_end;
        logic             wrap;

        assign sel    = div_sel[k*DIV_W +: DIV_W];
        assign d_cur  = eff_div(ratio);
        assign at_end = (cnt == (d_cur - 1'b1));
        // A wrap is the edge leaving cnt=D-1 while the channel is counting,
        // including the final edge of STOPPING that drops into IDLE.
        assign wrap   = (state != IDLE) && at_end;

        // Controller state register
        always_ff @(posedge pll_clk or negedge resetb) begin
            if (!resetb) begin
                state <= IDLE;
            end else begin
                state <= state_nxt;
            end
        end

        // Controller next-state: enable starts immediately, disable waits for period end
        always_comb begin
            state_nxt = state;
            case (state)
                IDLE: begin
                    if (ch_en[k]) state_nxt = RUN;
                end
                RUN: begin
                    if (!ch_en[k]) state_nxt = STOPPING;
                end
                STOPPING: begin
                    if (ch_en[k])    state_nxt = RUN;
                    else if (at_end) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Next counter, ratio bookkeeping and registered output values
        always_comb begin
            cnt_nxt      = cnt;
            ratio_nxt    = ratio;
            pend_nxt     = pend;
            pend_vld_nxt = pend_vld;
            idle_ld_nxt  = 1'b0;
            rst_cnt_nxt  = rst_cnt;
            // A ratio loaded while idle reports completion one cycle after it lands.
            done_nxt     = idle_ld;

            if (state == IDLE) begin
                cnt_nxt = '0;
                if (div_load[k]) begin
                    ratio_nxt    = sel;
                    pend_vld_nxt = 1'b0;
                    idle_ld_nxt  = 1'b1;
                end
            end else if (wrap) begin
                cnt_nxt = '0;
                if (rst_cnt != RST_MAX) rst_cnt_nxt = rst_cnt + 4'd1;
                // A load arriving on the wrap cycle itself wins over an older pending value.
                if (div_load[k]) begin
                    ratio_nxt    = sel;
                    pend_vld_nxt = 1'b0;
                    done_nxt     = 1'b1;
                end else if (pend_vld) begin
                    ratio_nxt    = pend;
                    pend_vld_nxt = 1'b0;
                    done_nxt     = 1'b1;
                end
            end else begin
                cnt_nxt = cnt + 1'b1;
                if (div_load[k]) begin
                    pend_nxt     = sel;
                    pend_vld_nxt = 1'b1;
                end
            end

            // High for the first floor(D/2) counts of each period, low when idle.
            clk_nxt = (state_nxt != IDLE) && (cnt_nxt < (eff_div(ratio_nxt) >> 1));
        end

        // Channel datapath registers, all cleared asynchronously by resetb
        always_ff @(posedge pll_clk or negedge resetb) begin
            if (!resetb) begin
                cnt      <= '0;
                ratio    <= RATIO_INIT;
                pend     <= '0;
                pend_vld <= 1'b0;
                idle_ld  <= 1'b0;
                clk_q    <= 1'b0;
                done_q   <= 1'b0;
                rst_cnt  <= '0;
            end else begin
                cnt      <= cnt_nxt;
                ratio    <= ratio_nxt;
                pend     <= pend_nxt;
                pend_vld <= pend_vld_nxt;
                idle_ld  <= idle_ld_nxt;
                clk_q    <= clk_nxt;
                done_q   <= done_nxt;
                rst_cnt  <= rst_cnt_nxt;
            end
        end

        assign clk_out[k]     = clk_q;
        assign div_done[k]    = done_q;
        // ext_reset overrides the staged release without disturbing the period count.
        assign resetb_sync[k] = (rst_cnt == RST_MAX) && !ext_reset;
    end

endmodule

// File: tb/tb_multi_clock_div.sv
// Randomized scoreboard bench for multi_clock_div. A behavioural model predicts
// each channel's outputs from its position within the current output period.
module tb_multi_clock_div;
    localparam int NUM_CH     = 2;
    localparam int DIV_W      = 3;
    localparam int DIV_RESET  = 2;
    localparam int RST_STAGES = 3;

    logic                    pll_clk   = 1'b0;
    logic                    resetb    = 1'b0;
    logic                    ext_reset = 1'b0;
    logic [NUM_CH-1:0]       ch_en     = '0;
    logic [NUM_CH*DIV_W-1:0] div_sel   = '0;
    logic [NUM_CH-1:0]       div_load  = '0;
    wire  [NUM_CH-1:0]       clk_out;
    wire  [NUM_CH-1:0]       div_done;
    wire  [NUM_CH-1:0]       resetb_sync;

    multi_clock_div #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DIV_RESET(DIV_RESET), .RST_STAGES(RST_STAGES)
    ) dut (
        .pll_clk(pll_clk), .resetb(resetb), .ext_reset(ext_reset),
        .ch_en(ch_en), .div_sel(div_sel), .div_load(div_load),
        .clk_out(clk_out), .div_done(div_done), .resetb_sync(resetb_sync)
    );

    always #5 pll_clk = ~pll_clk;

    typedef struct packed {
        logic [NUM_CH-1:0] c;
        logic [NUM_CH-1:0] d;
        logic [NUM_CH-1:0] r;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural model state: mode 0=idle 1=running 2=stopping
    int m_mode[NUM_CH];
    int m_pos[NUM_CH];
    int m_ratio[NUM_CH];
    int m_pend[NUM_CH];
    bit m_pend_v[NUM_CH];
    bit m_sched[NUM_CH];
    int m_periods[NUM_CH];
    bit m_done[NUM_CH];

    function automatic int eff(input int r);
        return (r < 2) ? 2 : r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_mode[k]    = 0;
            m_pos[k]     = 0;
            m_ratio[k]   = DIV_RESET;
            m_pend[k]    = 0;
            m_pend_v[k]  = 1'b0;
            m_sched[k]   = 1'b0;
            m_periods[k] = 0;
            m_done[k]    = 1'b0;
        end
    endtask

    // Advance the model by one pll_clk edge with the given inputs.
    task automatic model_edge(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] ld,
                              input logic [NUM_CH*DIV_W-1:0] sel);
        for (int k = 0; k < NUM_CH; k++) begin
            int s;
            bit last;
            s         = int'(sel[k*DIV_W +: DIV_W]);
            m_done[k] = m_sched[k];
            m_sched[k] = 1'b0;
            if (m_mode[k] == 0) begin
                if (ld[k]) begin
                    m_ratio[k] = s;
                    m_sched[k] = 1'b1;
                end
                m_pos[k] = 0;
                if (en[k]) m_mode[k] = 1;
            end else begin
                last = (m_pos[k] == eff(m_ratio[k]) - 1);
                if (last) begin
                    m_pos[k] = 0;
                    if (m_periods[k] < RST_STAGES) m_periods[k]++;
                    if (ld[k]) begin
                        m_ratio[k]  = s;
                        m_pend_v[k] = 1'b0;
                        m_done[k]   = 1'b1;
                    end else if (m_pend_v[k]) begin
                        m_ratio[k]  = m_pend[k];
                        m_pend_v[k] = 1'b0;
                        m_done[k]   = 1'b1;
                    end
                end else begin
                    m_pos[k]++;
                    if (ld[k]) begin
                        m_pend[k]   = s;
                        m_pend_v[k] = 1'b1;
                    end
                end
                if (m_mode[k] == 1 && !en[k])      m_mode[k] = 2;
                else if (m_mode[k] == 2 && en[k])  m_mode[k] = 1;
                else if (m_mode[k] == 2 && last)   m_mode[k] = 0;
            end
        end
    endtask

    function automatic exp_t model_out(input logic ext);
        exp_t e;
        e = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            e.c[k] = (m_mode[k] != 0) && (m_pos[k] < eff(m_ratio[k]) / 2);
            e.d[k] = m_done[k];
            e.r[k] = (m_periods[k] == RST_STAGES) && !ext;
        end
        return e;
    endfunction

    // Monitor: one output vector per cycle, checked away from the rising edge.
    initial begin
        forever begin
            @(negedge pll_clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                vectors++;
                if ({clk_out, div_done, resetb_sync} !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got clk=%b done=%b rsync=%b want clk=%b done=%b rsync=%b",
                             $time, clk_out, div_done, resetb_sync, e.c, e.d, e.r);
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit release_pending;
        release_pending = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({clk_out, div_done, resetb_sync} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got %b want 0", {clk_out, div_done, resetb_sync});
        end
        repeat (3) begin
            @(negedge pll_clk); #1;
            sb.push_back('0);
        end
        @(negedge pll_clk); #1;
        resetb = 1'b1;
        model_edge(ch_en, div_load, div_sel);
        sb.push_back(model_out(ext_reset));

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge pll_clk); #1;
            if (release_pending) begin
                resetb = 1'b1;
                release_pending = 1'b0;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(0, 15) == 0) ch_en[k] = ~ch_en[k];
                div_load[k] = ($urandom_range(0, 5) == 0);
            end
            div_sel = (NUM_CH*DIV_W)'($urandom);
            if ($urandom_range(0, 39) == 0) ext_reset = ~ext_reset;

            if (cyc > 20 && $urandom_range(0, 399) == 0) begin
                // Asynchronous reset between edges: outputs must clear at once.
                resetb = 1'b0;
                #1;
                vectors++;
                if ({clk_out, div_done, resetb_sync} !== '0) begin
                    miscompares++;
                    $display("FAIL async_reset got %b want 0", {clk_out, div_done, resetb_sync});
                end
                model_reset();
                sb.push_back('0);
                release_pending = 1'b1;
            end else begin
                model_edge(ch_en, div_load, div_sel);
                sb.push_back(model_out(ext_reset));
            end
        end

        @(negedge pll_clk);
        @(negedge pll_clk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
